// File: rtl/clock_ctrl_pkg.sv
// Shared types and default widths for the SAP-1 clock-enable scheduler.
package clock_ctrl_pkg;

    localparam int unsigned DIV_WIDTH_DEF = 24;
    localparam int unsigned CNT_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Auto-mode rate divider: asserts tick once every max(div,1) enabled cycles.
module tick_prescaler
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 clear,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;
    logic [DIV_WIDTH-1:0] last;

    // >= rather than == so lowering div below the running count ends the period at once
    always_comb begin
        last = (div == '0) ? '0 : div - DIV_WIDTH'(1);
        tick = en && (cnt_q >= last);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_step_ctrl.sv
// CPU clock-enable scheduler: manual single-step, auto free-run, sticky halt.
module clock_step_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 step_pb_down,
    input  logic                 mode_pb_down,
    input  logic                 hlt,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 cpu_ce,
    output logic                 mode_auto,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    state_e               state_q;
    state_e               state_d;
    logic                 cpu_ce_q;
    logic                 cpu_ce_d;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic                 psc_clear;
    logic                 psc_en;
    logic                 psc_tick;
    logic                 fire_ok;

    tick_prescaler #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_prescaler (
        .clk  (clk),
        .clr  (clr),
        .clear(psc_clear),
        .en   (psc_en),
        .div  (div),
        .tick (psc_tick)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= MANUAL;
            cpu_ce_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cpu_ce_q <= cpu_ce_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (hlt) begin
            state_d = HALTED;
        end else if (mode_pb_down) begin
            case (state_q)
                MANUAL:  state_d = AUTO;
                AUTO:    state_d = MANUAL;
                default: state_d = state_q;
            endcase
        end
    end

    // hlt and a mode press both suppress any enable that would coincide with them
    always_comb begin
        fire_ok   = !hlt && !mode_pb_down;
        psc_clear = mode_pb_down && (state_q != HALTED);
        psc_en    = (state_q == AUTO) && !hlt;
        cpu_ce_d  = 1'b0;
        case (state_q)
            MANUAL:  cpu_ce_d = fire_ok && step_pb_down;
            AUTO:    cpu_ce_d = fire_ok && psc_tick;
            default: cpu_ce_d = 1'b0;
        endcase
        count_d     = count_q + CNT_WIDTH'(cpu_ce_q);
        cpu_ce      = cpu_ce_q;
        mode_auto   = (state_q == AUTO);
        halted      = (state_q == HALTED);
        cycle_count = count_q;
    end

endmodule
